// File: rtl/chess_pkg.sv
// chess_pkg: piece encodings, descriptor codes and shared types for the move decoder
package chess_pkg;
  localparam logic [4:0] T_PAWN = 5'b00010, T_KNIGHT = 5'b00001, T_KING = 5'b00100;
  localparam logic [4:0] T_QUEEN = 5'b11000, T_ROOK = 5'b10000, T_BISHOP = 5'b01000;
  localparam logic [5:0] M_PAWN = 6'b000001, M_ROOK = 6'b000010, M_KNIGHT = 6'b000100;
  localparam logic [5:0] M_BISHOP = 6'b001000, M_QUEEN = 6'b010000, M_KING = 6'b100000;
  localparam logic [2:0] C_NONE = 3'b001, C_QUEEN = 3'b010, C_KING = 3'b100;
  localparam logic [4:0] EP_NONE = 5'b00001, EP_UL = 5'b00010, EP_UR = 5'b00100;
  localparam logic [4:0] EP_DL = 5'b01000, EP_DR = 5'b10000;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, RESOLVE, DONE} state_e;
  typedef struct packed {
    logic [63:0] init;
    logic [63:0] moved;
    logic [5:0]  moving;
    logic [5:0]  captured;
    logic [2:0]  castling;
    logic [4:0]  enpassant;
    logic        err;
  } desc_t;
  localparam desc_t DESC_RST = '{init: '0, moved: '0, moving: '0, captured: '0,
                                 castling: C_NONE, enpassant: EP_NONE, err: 1'b0};
  typedef struct packed {
    logic [2:0]      n_vac, n_arr, n_ep, n_err;
    logic [1:0][5:0] vsq, asq;
    logic [1:0][4:0] vty, aty;
    logic            a_empty;
    logic [4:0]      cap;
    logic [2:0]      erk;
    logic [4:0]      ety;
  } acc_t;
  function automatic logic [5:0] type_onehot(input logic [4:0] t);
    return t == T_PAWN   ? M_PAWN   :
           t == T_ROOK   ? M_ROOK   :
           t == T_KNIGHT ? M_KNIGHT :
           t == T_BISHOP ? M_BISHOP :
           t == T_QUEEN  ? M_QUEEN  :
           t == T_KING   ? M_KING   : 6'd0;
  endfunction
  function automatic logic [2:0] sat_inc(input logic [2:0] n);
    return n == 3'd7 ? n : n + 3'd1;
  endfunction
endpackage

// File: rtl/board_move_decoder_if.sv
// board_move_decoder_if: move descriptor valid/ready bus
interface board_move_decoder_if;
  logic        out_valid, out_ready;
  logic [63:0] initialPosition, movedPosition;
  logic [5:0]  movingPiece, capturedPiece;
  logic [2:0]  castling;
  logic [4:0]  enpassant;
  logic        decode_error;
  modport master(output out_valid, initialPosition, movedPosition, movingPiece, capturedPiece,
                 castling, enpassant, decode_error, input out_ready);
  modport slave(input out_valid, initialPosition, movedPosition, movingPiece, capturedPiece,
                castling, enpassant, decode_error, output out_ready);
endinterface

// File: rtl/board_move_decoder_square_classifier.sv
// square_classifier: classifies one square's before/after difference from the mover's view
module square_classifier (
  input  logic [5:0] before_piece,
  input  logic [5:0] after_piece,
  input  logic       color,
  output logic       vacated,
  output logic       arrival,
  output logic       capture,
  output logic       ep_victim,
  output logic       err,
  output logic [4:0] ptype
);
  logic own_b, own_a, opp_b, diff;
  always_comb begin
    own_b = |before_piece && before_piece[5] == color;
    own_a = |after_piece && after_piece[5] == color;
    opp_b = |before_piece && before_piece[5] != color;
    diff = before_piece != after_piece;
    vacated = own_b && diff;
    arrival = own_a && diff;
    capture = arrival && opp_b;
    ep_victim = opp_b && after_piece == 6'd0;
    err = diff && !vacated && !arrival && !ep_victim;
    ptype = before_piece[4:0];
  end
endmodule

// File: rtl/board_move_decoder.sv
// board_move_decoder: scans before/after boards and recovers the move descriptor
module board_move_decoder
  import chess_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        color_type,
  input  logic                        start,
  output logic                        busy,
  output logic                        rd_en,
  output logic [5:0]                  rd_addr,
  input  logic [5:0]                  before_piece,
  input  logic [5:0]                  after_piece,
  board_move_decoder_if.master        mo
);
  state_e state_q, state_d;
  logic [5:0] addr_q, addr_d, sq_q, sq_d, kos, kds, ros, rds;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic color_q, color_d, accept, smp, kv, ka, normal, castle, ep, up, left;
  logic vac, arr, cap, epv, err;
  logic [4:0] ptype;
  acc_t acc_q, acc_d;
  desc_t desc_q, desc_d;
  square_classifier u_cls (
    .before_piece(before_piece), .after_piece(after_piece), .color(color_q),
    .vacated(vac), .arrival(arr), .capture(cap), .ep_victim(epv), .err(err), .ptype(ptype)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    accept = start && (state_q == IDLE || (state_q == DONE && mo.out_ready));
    state_d = state_q == IDLE    ? (accept ? SCAN : IDLE) :
              state_q == SCAN    ? (addr_q == 6'd63 ? DRAIN : SCAN) :
              state_q == DRAIN   ? (addr_q == 6'(READ_LATENCY - 1) ? RESOLVE : DRAIN) :
              state_q == RESOLVE ? DONE :
              mo.out_ready       ? (accept ? SCAN : IDLE) : DONE;
  end
  always_comb begin
    busy = state_q != IDLE;
    rd_en = state_q == SCAN;
    mo.out_valid = state_q == DONE;
  end
  assign rd_addr = addr_q;
  assign smp = vld_q[READ_LATENCY-1];
  always_comb begin
    addr_d = (state_q == SCAN || (state_q == DRAIN && state_d == DRAIN)) ? addr_q + 6'd1 : 6'd0;
    vld_d = vld_q << 1;
    vld_d[0] = rd_en;
    sq_d = accept ? 6'd0 : smp ? sq_q + 6'd1 : sq_q;
    color_d = accept ? color_type : color_q;
  end
  // read data returns in address order, so sq_q names the square currently on the bus
  always_comb begin
    acc_d = acc_q;
    if (accept) acc_d = '0;
    else if (smp) begin
      if (vac && acc_q.n_vac < 3'd2) begin
        acc_d.vsq[acc_q.n_vac[0]] = sq_q;
        acc_d.vty[acc_q.n_vac[0]] = ptype;
      end
      if (arr && acc_q.n_arr < 3'd2) begin
        acc_d.asq[acc_q.n_arr[0]] = sq_q;
        acc_d.aty[acc_q.n_arr[0]] = after_piece[4:0];
      end
      if (arr && acc_q.n_arr == 3'd0) acc_d.a_empty = before_piece == 6'd0;
      if (cap) acc_d.cap = ptype;
      if (epv) begin
        acc_d.erk = sq_q[5:3];
        acc_d.ety = ptype;
      end
      acc_d.n_vac = vac ? sat_inc(acc_q.n_vac) : acc_q.n_vac;
      acc_d.n_arr = arr ? sat_inc(acc_q.n_arr) : acc_q.n_arr;
      acc_d.n_ep = epv ? sat_inc(acc_q.n_ep) : acc_q.n_ep;
      acc_d.n_err = err ? sat_inc(acc_q.n_err) : acc_q.n_err;
    end
  end
  assign kv = acc_q.vty[0] != T_KING;
  assign ka = acc_q.aty[0] != T_KING;
  assign kos = acc_q.vsq[kv];
  assign ros = acc_q.vsq[~kv];
  assign kds = acc_q.asq[ka];
  assign rds = acc_q.asq[~ka];
  assign up = acc_q.asq[0][5:3] > acc_q.vsq[0][5:3];
  assign left = acc_q.asq[0][2:0] < acc_q.vsq[0][2:0];
  always_comb begin
    normal = acc_q.n_vac == 3'd1 && acc_q.n_arr == 3'd1 && acc_q.n_ep == 3'd0 && acc_q.n_err == 3'd0;
    castle = acc_q.n_vac == 3'd2 && acc_q.n_arr == 3'd2 && acc_q.n_ep == 3'd0 && acc_q.n_err == 3'd0 &&
             acc_q.cap == 5'd0 && acc_q.vty[kv] == T_KING && acc_q.vty[~kv] == T_ROOK &&
             acc_q.aty[ka] == T_KING && acc_q.aty[~ka] == T_ROOK &&
             ros[5:3] == kos[5:3] && kds[5:3] == kos[5:3] && rds[5:3] == kos[5:3];
    ep = acc_q.n_vac == 3'd1 && acc_q.n_arr == 3'd1 && acc_q.n_ep == 3'd1 && acc_q.n_err == 3'd0 &&
         acc_q.vty[0] == T_PAWN && acc_q.a_empty && acc_q.ety == T_PAWN &&
         acc_q.erk == acc_q.vsq[0][5:3];
    desc_d = desc_q;
    if (state_q == RESOLVE) begin
      desc_d.init = normal || ep ? 64'd1 << acc_q.vsq[0] : castle ? 64'd1 << kos : 64'd0;
      desc_d.moved = normal || ep ? 64'd1 << acc_q.asq[0] : castle ? 64'd1 << kds : 64'd0;
      desc_d.moving = normal || ep ? type_onehot(acc_q.vty[0]) : castle ? M_KING : 6'd0;
      desc_d.captured = normal ? type_onehot(acc_q.cap) : ep ? M_PAWN : 6'd0;
      desc_d.castling = castle ? (kds[2:0] > kos[2:0] ? C_KING : C_QUEEN) : C_NONE;
      desc_d.enpassant = ep ? (up ? (left ? EP_UL : EP_UR) : (left ? EP_DL : EP_DR)) : EP_NONE;
      desc_d.err = !(normal || castle || ep);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      vld_q <= '0;
      sq_q <= '0;
      color_q <= 1'b0;
      acc_q <= '0;
      desc_q <= DESC_RST;
    end else begin
      addr_q <= addr_d;
      vld_q <= vld_d;
      sq_q <= sq_d;
      color_q <= color_d;
      acc_q <= acc_d;
      desc_q <= desc_d;
    end
  end
  assign mo.initialPosition = desc_q.init;
  assign mo.movedPosition = desc_q.moved;
  assign mo.movingPiece = desc_q.moving;
  assign mo.capturedPiece = desc_q.captured;
  assign mo.castling = desc_q.castling;
  assign mo.enpassant = desc_q.enpassant;
  assign mo.decode_error = desc_q.err;
endmodule

// File: tb/tb_board_move_decoder.sv
// tb_board_move_decoder: random and directed moves checked against a rule-level board-diff model
module tb_board_move_decoder;
  logic clk = 1'b0;
  logic reset, color_type, start, busy, rd_en;
  logic [5:0] rd_addr, before_piece, after_piece;
  logic [5:0] bb [64];
  logic [5:0] ab [64];
  logic col, exp_valid;
  logic [148:0] exp_vec, nexp;
  int tests = 0, fails = 0;
  board_move_decoder_if bus ();
  board_move_decoder #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .color_type(color_type), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .before_piece(before_piece), .after_piece(after_piece),
    .mo(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) begin
    before_piece <= bb[rd_addr];
    after_piece <= ab[rd_addr];
  end
  wire [148:0] dut_vec = {bus.initialPosition, bus.movedPosition, bus.movingPiece,
                          bus.capturedPiece, bus.castling, bus.enpassant, bus.decode_error};
  task automatic check(input string nm, input logic [148:0] a, input logic [148:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  always @(negedge clk) if (!reset && bus.out_valid) begin
    if (exp_valid) check("descriptor", dut_vec, exp_vec);
    else check("unexpected_out_valid", 149'(bus.out_valid), 149'd0);
  end
  function automatic logic [5:0] oh(input logic [4:0] t);
    case (t)
      5'b00010: return 6'b000001;
      5'b10000: return 6'b000010;
      5'b00001: return 6'b000100;
      5'b01000: return 6'b001000;
      5'b11000: return 6'b010000;
      5'b00100: return 6'b100000;
      default:  return 6'b000000;
    endcase
  endfunction
  function automatic logic [148:0] pack(input logic [63:0] ip, mp, input logic [5:0] mv, cp,
                                        input logic [2:0] cs, input logic [4:0] ep, input logic e);
    return {ip, mp, mv, cp, cs, ep, e};
  endfunction
  // Expected descriptor straight from the move rules over the whole board
  function automatic logic [148:0] model();
    int vac[$], arr[$], epv[$];
    int nerr, ko, ro, kd, rdst;
    bit ob, oa, pb, any, capany, ok;
    logic [63:0] ip, mp;
    logic [5:0] mv, cp;
    logic [2:0] cs;
    logic [4:0] ep;
    nerr = 0; capany = 0; ok = 0;
    ip = 0; mp = 0; mv = 0; cp = 0; cs = 3'b001; ep = 5'b00001;
    for (int s = 0; s < 64; s++) begin
      if (bb[s] == ab[s]) continue;
      ob = bb[s] != 0 && bb[s][5] == col;
      oa = ab[s] != 0 && ab[s][5] == col;
      pb = bb[s] != 0 && bb[s][5] != col;
      any = 0;
      if (ob) begin vac.push_back(s); any = 1; end
      if (oa) begin arr.push_back(s); any = 1; if (pb) capany = 1; end
      if (pb && ab[s] == 0) begin epv.push_back(s); any = 1; end
      if (!any) nerr++;
    end
    if (vac.size() == 1 && arr.size() == 1 && epv.size() == 0 && nerr == 0) begin
      ok = 1;
      ip = 64'd1 << vac[0]; mp = 64'd1 << arr[0]; mv = oh(bb[vac[0]][4:0]);
      cp = (bb[arr[0]] != 0 && bb[arr[0]][5] != col) ? oh(bb[arr[0]][4:0]) : 6'd0;
    end
    if (!ok && vac.size() == 2 && arr.size() == 2 && epv.size() == 0 && nerr == 0 && !capany) begin
      ko = bb[vac[0]][4:0] == 5'b00100 ? vac[0] : vac[1];
      ro = ko == vac[0] ? vac[1] : vac[0];
      kd = ab[arr[0]][4:0] == 5'b00100 ? arr[0] : arr[1];
      rdst = kd == arr[0] ? arr[1] : arr[0];
      if (bb[ko][4:0] == 5'b00100 && bb[ro][4:0] == 5'b10000 && ab[kd][4:0] == 5'b00100 &&
          ab[rdst][4:0] == 5'b10000 && ko / 8 == ro / 8 && kd / 8 == ko / 8 && rdst / 8 == ko / 8) begin
        ok = 1;
        ip = 64'd1 << ko; mp = 64'd1 << kd; mv = 6'b100000;
        cs = kd % 8 > ko % 8 ? 3'b100 : 3'b010;
      end
    end
    if (!ok && vac.size() == 1 && arr.size() == 1 && epv.size() == 1 && nerr == 0 &&
        bb[vac[0]][4:0] == 5'b00010 && bb[arr[0]] == 0 && bb[epv[0]][4:0] == 5'b00010 &&
        epv[0] / 8 == vac[0] / 8) begin
      ok = 1;
      ip = 64'd1 << vac[0]; mp = 64'd1 << arr[0]; mv = 6'b000001; cp = 6'b000001;
      ep = arr[0] / 8 > vac[0] / 8 ? (arr[0] % 8 < vac[0] % 8 ? 5'b00010 : 5'b00100)
                                   : (arr[0] % 8 < vac[0] % 8 ? 5'b01000 : 5'b10000);
    end
    return pack(ip, mp, mv, cp, cs, ep, !ok);
  endfunction
  function automatic logic [5:0] pc(input logic c, input int k);
    case (k)
      0: return {c, 5'b00010};
      1: return {c, 5'b00001};
      2: return {c, 5'b00100};
      3: return {c, 5'b11000};
      4: return {c, 5'b10000};
      default: return {c, 5'b01000};
    endcase
  endfunction
  task automatic clear_boards();
    for (int s = 0; s < 64; s++) begin bb[s] = 0; ab[s] = 0; end
  endtask
  task automatic gen_random();
    int kind, s, d, v, sr, sf, dr, df, r, side;
    logic [5:0] p;
    col = 1'($urandom_range(0, 1));
    for (int i = 0; i < 64; i++) bb[i] = $urandom_range(0, 3) == 0 ? pc(1'($urandom_range(0, 1)), $urandom_range(0, 5)) : 6'd0;
    kind = $urandom_range(0, 4);
    if (kind <= 1) begin
      s = $urandom_range(0, 63);
      do d = $urandom_range(0, 63); while (d == s);
      p = pc(col, $urandom_range(0, 5));
      bb[s] = p;
      bb[d] = kind == 1 ? pc(~col, $urandom_range(0, 5)) : 6'd0;
      ab = bb; ab[s] = 0;
      ab[d] = (p[4:0] == 5'b00010 && $urandom_range(0, 3) == 0) ? pc(col, 3) : p;
    end else if (kind == 2) begin
      r = col ? 0 : 7; side = $urandom_range(0, 1);
      for (int f = 0; f < 8; f++) bb[r * 8 + f] = 0;
      bb[r * 8 + 4] = pc(col, 2); bb[r * 8 + (side ? 7 : 0)] = pc(col, 4);
      ab = bb; ab[r * 8 + 4] = 0; ab[r * 8 + (side ? 7 : 0)] = 0;
      ab[r * 8 + (side ? 6 : 2)] = pc(col, 2); ab[r * 8 + (side ? 5 : 3)] = pc(col, 4);
    end else if (kind == 3) begin
      sr = $urandom_range(1, 6); sf = $urandom_range(0, 7);
      df = sf == 0 ? 1 : sf == 7 ? 6 : ($urandom_range(0, 1) ? sf + 1 : sf - 1);
      dr = $urandom_range(0, 1) ? sr + 1 : sr - 1;
      s = sr * 8 + sf; d = dr * 8 + df; v = sr * 8 + df;
      bb[s] = pc(col, 0); bb[d] = 0; bb[v] = pc(~col, 0);
      ab = bb; ab[s] = 0; ab[d] = pc(col, 0); ab[v] = 0;
    end else begin
      ab = bb;
      repeat ($urandom_range(1, 3)) ab[$urandom_range(0, 63)] = $urandom_range(0, 1) ? 6'd0 : pc(1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      start = n == 10;
      @(negedge clk); n++;
    end
    start = 0;
    check("latency", 149'(n), 149'd66);
  endtask
  task automatic launch();
    @(negedge clk);
    exp_vec = model(); exp_valid = 1; color_type = col; start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    check("scan_begins", 149'({busy, rd_en, rd_addr, bus.out_valid}), 149'({1'b1, 1'b1, 6'd0, 1'b0}));
    wait_valid();
  endtask
  task automatic finish_hs(input int hold, input bit restart);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1; start = restart; color_type = col;
    @(posedge clk);
    @(negedge clk); bus.out_ready = 0; start = 0;
    check("busy_after_handshake", 149'(busy), 149'(restart));
    check("valid_after_handshake", 149'(bus.out_valid), 149'd0);
    if (!restart) exp_valid = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit chain;
    int seen;
    reset = 1; start = 0; color_type = 0; bus.out_ready = 0; exp_valid = 0; col = 1;
    before_piece = 0; after_piece = 0; clear_boards();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset_ctrl", 149'({busy, rd_en, rd_addr, bus.out_valid}), 149'd0);
    check("reset_desc", dut_vec, pack(0, 0, 0, 0, 3'b001, 5'b00001, 0));
    clear_boards(); col = 1; bb[12] = 6'b100010; ab[28] = 6'b100010; bb[60] = 6'b000100; ab[60] = 6'b000100;
    check("pin_pawn", model(), pack(64'd1 << 12, 64'd1 << 28, 6'b000001, 0, 3'b001, 5'b00001, 0));
    launch(); finish_hs(1, 0);
    clear_boards(); bb[21] = 6'b100001; bb[36] = 6'b001000; ab[36] = 6'b100001;
    check("pin_knight", model(), pack(64'd1 << 21, 64'd1 << 36, 6'b000100, 6'b001000, 3'b001, 5'b00001, 0));
    launch(); finish_hs(0, 0);
    clear_boards(); bb[4] = 6'b100100; bb[7] = 6'b110000; ab[6] = 6'b100100; ab[5] = 6'b110000;
    check("pin_castle", model(), pack(64'd1 << 4, 64'd1 << 6, 6'b100000, 0, 3'b100, 5'b00001, 0));
    launch(); finish_hs(2, 0);
    clear_boards(); bb[36] = 6'b100010; bb[35] = 6'b000010; ab[43] = 6'b100010;
    check("pin_enpassant", model(), pack(64'd1 << 36, 64'd1 << 43, 6'b000001, 6'b000001, 3'b001, 5'b00010, 0));
    launch(); finish_hs(0, 0);
    clear_boards(); bb[10] = 6'b110000; ab[10] = 6'b110000;
    check("pin_identical", model(), pack(0, 0, 0, 0, 3'b001, 5'b00001, 1));
    launch(); finish_hs(5, 0);
    clear_boards(); bb[12] = 6'b100010; ab[28] = 6'b100010;
    @(negedge clk); color_type = 1; start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (29) @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk); reset = 0;
    check("abort_ctrl", 149'({busy, rd_en, bus.out_valid}), 149'd0);
    seen = 0;
    repeat (80) begin @(negedge clk); seen += int'(bus.out_valid); end
    check("abort_no_valid", 149'(seen), 149'd0);
    launch(); finish_hs(0, 0);
    gen_random(); launch();
    for (int i = 0; i < 40; i++) begin
      chain = i < 39 && $urandom_range(0, 2) == 0;
      if (chain) begin
        gen_random(); nexp = model();
        finish_hs($urandom_range(0, 3), 1);
        exp_vec = nexp;
        wait_valid();
      end else begin
        finish_hs($urandom_range(0, 3), 0);
        if (i < 39) begin gen_random(); launch(); end
      end
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
